// File: rtl/sram_arbiter.sv
// SRAM arbiter: shares one synchronous-read SRAM port between a CRTC DMA
// burst engine and a CPU. DMA bursts have priority, but after MAX_HOLD
// consecutive bytes a pending CPU access is slotted in before the burst resumes.
module sram_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_req,
    input  logic [15:0] dma_base,
    input  logic [7:0]  dma_len,
    output logic        dma_ack,
    output logic        dma_valid,
    output logic        dma_done,
    input  logic        cpu_mreq,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_wait,
    output logic [15:0] ram_adr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CPU_ACC  = 3'd1;
    localparam logic [2:0] CPU_DONE = 3'd2;
    localparam logic [2:0] DMA_RUN  = 3'd3;
    localparam logic [2:0] DMA_TAIL = 3'd4;
    localparam logic [2:0] DMA_GAP  = 3'd5;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [2:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;        // next DMA address to issue
    logic [8:0]  rem_q, rem_d;          // DMA bytes still to issue (1..256)
    logic [7:0]  hold_q, hold_d;        // DMA bytes since burst start / last CPU slot
    logic        armed_q, armed_d;      // one CPU access per cpu_mreq assertion
    logic        from_gap_q, from_gap_d;
    logic        valid_q;
    logic [15:0] ram_adr_q;

    logic        cpu_req;
    logic        last_byte;
    logic [7:0]  hold_inc;
    logic        hold_hit;

    assign cpu_req   = cpu_mreq & (cpu_rd | cpu_wr) & armed_q;
    assign last_byte = (rem_q == 9'd1);
    // Saturate so a long burst with no CPU demand cannot wrap the hold count.
    assign hold_inc  = (hold_q >= HOLD_LIMIT) ? hold_q : hold_q + 8'd1;
    assign hold_hit  = (hold_inc >= HOLD_LIMIT);

    // Next-state, burst address/count and hold-count logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        hold_d     = hold_q;
        from_gap_d = from_gap_q;
        case (state_q)
            IDLE: begin
                if (dma_req) begin
                    state_d = DMA_RUN;
                    addr_d  = dma_base;
                    rem_d   = (dma_len == 8'd0) ? 9'd256 : {1'b0, dma_len};
                    hold_d  = 8'd0;
                end else if (cpu_req) begin
                    state_d    = CPU_ACC;
                    from_gap_d = 1'b0;
                end
            end
            CPU_ACC: begin
                state_d = CPU_DONE;
            end
            CPU_DONE: begin
                from_gap_d = 1'b0;
                if (from_gap_q && (rem_q != 9'd0)) begin
                    state_d = DMA_RUN;
                    hold_d  = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DMA_RUN: begin
                addr_d = addr_q + 16'd1;
                rem_d  = rem_q - 9'd1;
                hold_d = hold_inc;
                if (last_byte) begin
                    state_d = DMA_TAIL;
                end else if (hold_hit && cpu_req) begin
                    state_d = DMA_GAP;
                end
            end
            DMA_TAIL: begin
                state_d = IDLE;
            end
            DMA_GAP: begin
                state_d    = CPU_ACC;
                from_gap_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arm flag: cleared when the CPU access is taken, re-armed once cpu_mreq drops.
    always_comb begin
        armed_d = armed_q;
        if ((state_d == CPU_ACC) && (state_q != CPU_ACC)) begin
            armed_d = 1'b0;
        end else if (!cpu_mreq) begin
            armed_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 16'h0000;
            rem_q      <= 9'd0;
            hold_q     <= 8'd0;
            armed_q    <= 1'b1;
            from_gap_q <= 1'b0;
            valid_q    <= 1'b0;
            ram_adr_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            hold_q     <= hold_d;
            armed_q    <= armed_d;
            from_gap_q <= from_gap_d;
            // SRAM data for a DMA address appears one cycle after it is issued.
            valid_q    <= (state_q == DMA_RUN);
            ram_adr_q  <= ram_adr;
        end
    end

    // SRAM port mux; the address holds its last value when no one owns the port.
    always_comb begin
        ram_adr = ram_adr_q;
        ram_we  = 1'b0;
        case (state_q)
            CPU_ACC: begin
                ram_adr = cpu_adr;
                ram_we  = cpu_wr;
            end
            DMA_RUN: begin
                ram_adr = addr_q;
            end
            default: begin
                ram_adr = ram_adr_q;
            end
        endcase
    end

    assign ram_wdata = cpu_din;
    assign dma_valid = valid_q;
    assign dma_done  = (state_q == DMA_TAIL);
    // Ack covers the whole burst, including a CPU slot borrowed from the middle.
    assign dma_ack   = (state_q == DMA_RUN) || (state_q == DMA_TAIL) || (state_q == DMA_GAP) ||
                       (((state_q == CPU_ACC) || (state_q == CPU_DONE)) && from_gap_q);
    // Gated by reset so the CPU is never stalled while the arbiter is held in reset.
    assign cpu_wait  = ~reset & ((state_q == CPU_ACC) || (cpu_req && (state_q != CPU_DONE)));

endmodule
